// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if
//   Request/response bundle between the two ALU requesters and alu_share_ctrl.
//   slave  : the controller side (accepts requests, issues responses).
//   master : the requester side (issues requests, takes responses).
//   Signals:
//     rX_valid/rX_ready         request handshake for requester X
//     rX_sel/rX_a/rX_b          op code and operands
//     rX_cin/rX_sign            carry-in and signed-overflow select
//     rX_rsp_valid/rX_rsp_ready response handshake for requester X
//     rsp_data/rsp_zero/rsp_ovf captured result, shared by both requesters
interface alu_share_ctrl_if;
    logic        r0_valid;
    logic        r0_ready;
    logic [3:0]  r0_sel;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic        r0_cin;
    logic        r0_sign;
    logic        r0_rsp_valid;
    logic        r0_rsp_ready;

    logic        r1_valid;
    logic        r1_ready;
    logic [3:0]  r1_sel;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic        r1_cin;
    logic        r1_sign;
    logic        r1_rsp_valid;
    logic        r1_rsp_ready;

    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_ovf;

    modport slave (
        input  r0_valid, r0_sel, r0_a, r0_b, r0_cin, r0_sign, r0_rsp_ready,
        input  r1_valid, r1_sel, r1_a, r1_b, r1_cin, r1_sign, r1_rsp_ready,
        output r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        output rsp_data, rsp_zero, rsp_ovf
    );

    modport master (
        output r0_valid, r0_sel, r0_a, r0_b, r0_cin, r0_sign, r0_rsp_ready,
        output r1_valid, r1_sel, r1_a, r1_b, r1_cin, r1_sign, r1_rsp_ready,
        input  r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        input  rsp_data, rsp_zero, rsp_ovf
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one 32-bit ALU between two requesters. Requests are arbitrated
//   round-robin, operands are registered onto the ALU, multiply (op 4'h2) is
//   held for MUL_CYCLES cycles, and the captured result/flags are returned to
//   the winning requester through a response handshake.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     bus (slave)         request/response handshakes of both requesters
//     alu_a/alu_b         registered operands driven to the ALU
//     alu_sel             registered op code
//     alu_cin/alu_sign    registered carry-in / signed-overflow select
//     alu_out/alu_zero/alu_ovf  combinational ALU result and flags
//     busy                high whenever the controller is not idle
module alu_share_ctrl #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_share_ctrl_if.slave          bus,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [3:0]               alu_sel,
    output logic                     alu_cin,
    output logic                     alu_sign,
    input  logic [31:0]              alu_out,
    input  logic                     alu_zero,
    input  logic                     alu_ovf,
    output logic                     busy
);

    localparam logic [3:0] OpMul   = 4'h2;
    localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q;
    logic        owner_q;
    logic [3:0]  cnt_q;
    logic [31:0] alu_a_q, alu_b_q;
    logic [3:0]  alu_sel_q;
    logic        alu_cin_q, alu_sign_q;
    logic [31:0] rsp_data_q;
    logic        rsp_zero_q, rsp_ovf_q;

    logic        any_valid;
    logic        winner;
    logic        accept;
    logic        capture;
    logic        owner_rsp_ready;
    logic [3:0]  win_sel;
    logic [31:0] win_a, win_b;
    logic        win_cin, win_sign;

    // Round-robin: on contention the requester that did not win last time goes.
    always_comb begin
        any_valid = bus.r0_valid | bus.r1_valid;
        if (bus.r0_valid && bus.r1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = bus.r1_valid;
        end
        win_sel         = winner ? bus.r1_sel  : bus.r0_sel;
        win_a           = winner ? bus.r1_a    : bus.r0_a;
        win_b           = winner ? bus.r1_b    : bus.r0_b;
        win_cin         = winner ? bus.r1_cin  : bus.r0_cin;
        win_sign        = winner ? bus.r1_sign : bus.r0_sign;
        owner_rsp_ready = owner_q ? bus.r1_rsp_ready : bus.r0_rsp_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                // Only the owner's rsp_ready completes the response.
                if (owner_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs. ready is masked during reset so every output reads 0 then.
    always_comb begin
        busy             = (state_q != StIdle);
        bus.r0_ready     = (state_q == StIdle) && !reset && any_valid && !winner;
        bus.r1_ready     = (state_q == StIdle) && !reset && any_valid && winner;
        bus.r0_rsp_valid = (state_q == StResp) && !owner_q;
        bus.r1_rsp_valid = (state_q == StResp) && owner_q;
        bus.rsp_data     = rsp_data_q;
        bus.rsp_zero     = rsp_zero_q;
        bus.rsp_ovf      = rsp_ovf_q;
        alu_a            = alu_a_q;
        alu_b            = alu_b_q;
        alu_sel          = alu_sel_q;
        alu_cin          = alu_cin_q;
        alu_sign         = alu_sign_q;
    end

    // Datapath: operand registers, owner/grant tracking, hold counter, capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 4'd0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_sel_q    <= 4'd0;
            alu_cin_q    <= 1'b0;
            alu_sign_q   <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q      <= win_a;
                alu_b_q      <= win_b;
                alu_sel_q    <= win_sel;
                alu_cin_q    <= win_cin;
                alu_sign_q   <= win_sign;
                owner_q      <= winner;
                last_grant_q <= winner;
                cnt_q        <= (win_sel == OpMul) ? MulLoad : 4'd0;
            end else if ((state_q == StExec) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                rsp_data_q <= alu_out;
                rsp_zero_q <= alu_zero;
                rsp_ovf_q  <= alu_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
//   Directed bench for alu_share_ctrl with a behavioural ALU and a scoreboard:
//   expected results are queued on request acceptance and checked on the
//   response handshake.
module tb_alu_share_ctrl;

    localparam int unsigned MulCycles = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_cin, alu_sign, alu_zero, alu_ovf, busy;
    logic [33:0] alu_res;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc_n    = 0;
    int          last_acc = 0;
    int          k        = 0;
    logic [34:0] sb_q[$];

    alu_share_ctrl_if bus ();

    alu_share_ctrl #(
        .MUL_CYCLES (MulCycles)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_cin  (alu_cin),
        .alu_sign (alu_sign),
        .alu_out  (alu_out),
        .alu_zero (alu_zero),
        .alu_ovf  (alu_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 add, 1 sub, 2 mul, 4 and, others return 0.
    // Result packing: {ovf, zero, data}.
    function automatic logic [33:0] alu_fn(input logic [3:0] sel, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin,
                                           input logic sign);
        logic [31:0] r;
        logic        ovf;
        r   = 32'd0;
        ovf = 1'b0;
        case (sel)
            4'h0: begin
                r   = a + b + {31'd0, cin};
                ovf = sign && (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                r   = a - b;
                ovf = sign && (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h2: r = a * b;
            4'h4: r = a & b;
            default: r = 32'd0;
        endcase
        return {ovf, (r == 32'd0), r};
    endfunction

    always_comb begin
        alu_res  = alu_fn(alu_sel, alu_a, alu_b, alu_cin, alu_sign);
        alu_out  = alu_res[31:0];
        alu_zero = alu_res[32];
        alu_ovf  = alu_res[33];
    end

    task automatic chk(input string tag, input logic ok);
        n_assert++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic check_rsp(input logic id);
        logic [34:0] e;
        chk("sb_nonempty", sb_q.size() != 0);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rsp_owner", id === e[34]);
            chk("rsp_data", bus.rsp_data === e[31:0]);
            chk("rsp_zero", bus.rsp_zero === e[32]);
            chk("rsp_ovf", bus.rsp_ovf === e[33]);
        end
    endtask

    // Runs at the falling edge: inputs are final for the coming rising edge.
    task automatic monitor();
        if (reset) begin
            sb_q.delete();
            return;
        end
        chk("one_ready", (bus.r0_ready & bus.r1_ready) === 1'b0);
        chk("one_rsp_valid", (bus.r0_rsp_valid & bus.r1_rsp_valid) === 1'b0);
        if (bus.r0_valid && bus.r0_ready) begin
            sb_q.push_back({1'b0, alu_fn(bus.r0_sel, bus.r0_a, bus.r0_b, bus.r0_cin,
                                         bus.r0_sign)});
        end
        if (bus.r1_valid && bus.r1_ready) begin
            sb_q.push_back({1'b1, alu_fn(bus.r1_sel, bus.r1_a, bus.r1_b, bus.r1_cin,
                                         bus.r1_sign)});
        end
        if (bus.r0_rsp_valid && bus.r0_rsp_ready) check_rsp(1'b0);
        if (bus.r1_rsp_valid && bus.r1_rsp_ready) check_rsp(1'b1);
    endtask

    // One clock: monitor at the falling edge, return 1 time unit after the rise.
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drive(input logic id, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic sign);
        if (id) begin
            bus.r1_sel = sel; bus.r1_a = a; bus.r1_b = b;
            bus.r1_cin = cin; bus.r1_sign = sign; bus.r1_valid = 1'b1;
        end else begin
            bus.r0_sel = sel; bus.r0_a = a; bus.r0_b = b;
            bus.r0_cin = cin; bus.r0_sign = sign; bus.r0_valid = 1'b1;
        end
        #1;
    endtask

    task automatic wait_ready(input logic id);
        for (int i = 0; i < 20; i++) begin
            if (id ? bus.r1_ready : bus.r0_ready) break;
            cyc();
        end
        chk("ready_seen", (id ? bus.r1_ready : bus.r0_ready) === 1'b1);
    endtask

    task automatic wait_rsp(input logic id);
        for (int i = 0; i < 30; i++) begin
            if (id ? bus.r1_rsp_valid : bus.r0_rsp_valid) break;
            cyc();
        end
        chk("rsp_seen", (id ? bus.r1_rsp_valid : bus.r0_rsp_valid) === 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_ops"}, {alu_a, alu_b} === 64'd0);
        chk({tag, "_alu_ctl"}, {alu_sel, alu_cin, alu_sign} === 6'd0);
        chk({tag, "_rsp"}, {bus.rsp_zero, bus.rsp_ovf, bus.rsp_data} === 34'd0);
        chk({tag, "_hs"}, {bus.r0_ready, bus.r1_ready, bus.r0_rsp_valid,
                           bus.r1_rsp_valid, busy} === 5'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.r0_valid = 1'b0; bus.r0_sel = 4'd0; bus.r0_a = 32'd0; bus.r0_b = 32'd0;
        bus.r0_cin = 1'b0; bus.r0_sign = 1'b0; bus.r0_rsp_ready = 1'b1;
        bus.r1_valid = 1'b0; bus.r1_sel = 4'd0; bus.r1_a = 32'd0; bus.r1_b = 32'd0;
        bus.r1_cin = 1'b0; bus.r1_sign = 1'b0; bus.r1_rsp_ready = 1'b1;
        cyc();
        cyc();
        check_reset_outputs("reset");
        reset = 1'b0;

        // Single add on r0: accept at once, response two edges later.
        drive(1'b0, 4'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("add_r0_ready", bus.r0_ready === 1'b1);
        chk("add_r1_ready", bus.r1_ready === 1'b0);
        cyc();
        bus.r0_valid = 1'b0;
        chk("add_alu_a", alu_a === 32'd5);
        chk("add_alu_b", alu_b === 32'd7);
        chk("add_alu_ctl", {alu_sel, alu_cin} === 5'h01);
        chk("add_busy", busy === 1'b1);
        chk("add_rsp_early", bus.r0_rsp_valid === 1'b0);
        cyc();
        chk("add_rsp_valid", bus.r0_rsp_valid === 1'b1);
        chk("add_r1_rsp_valid", bus.r1_rsp_valid === 1'b0);
        chk("add_rsp_data", bus.rsp_data === 32'd13);
        chk("add_rsp_flags", {bus.rsp_zero, bus.rsp_ovf} === 2'b00);
        cyc();
        chk("add_idle", {busy, bus.r0_rsp_valid} === 2'b00);

        // Contention from reset: both valid, grants must alternate 0,1,0,1.
        reset = 1'b1;
        drive(1'b0, 4'h1, 32'd3, 32'd3, 1'b0, 1'b0);
        drive(1'b1, 4'h4, 32'd1, 32'd1, 1'b0, 1'b0);
        chk("rst_ready_gated", {bus.r0_ready, bus.r1_ready} === 2'b00);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            while (!(bus.r0_ready || bus.r1_ready) && k < 20) begin
                cyc();
                k++;
            end
            chk("grant_order", bus.r1_ready === 1'(g % 2));
            if (g > 0) chk("grant_spacing", (cyc_n - last_acc) == 3);
            last_acc = cyc_n;
            cyc();
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        wait_rsp(1'b1);
        cyc();

        // Multiply on r1: operands held for MulCycles edges, then response.
        drive(1'b1, 4'h2, 32'd6, 32'd7, 1'b0, 1'b0);
        wait_ready(1'b1);
        cyc();
        bus.r1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mul_hold_ops", {alu_a, alu_b} === {32'd6, 32'd7});
            chk("mul_hold_sel", alu_sel === 4'd2);
            chk("mul_no_rsp", bus.r1_rsp_valid === 1'b0);
            cyc();
        end
        chk("mul_rsp_valid", bus.r1_rsp_valid === 1'b1);
        chk("mul_rsp_data", bus.rsp_data === 32'd42);
        cyc();

        // Signed overflow.
        drive(1'b0, 4'h0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        wait_ready(1'b0);
        cyc();
        bus.r0_valid = 1'b0;
        wait_rsp(1'b0);
        chk("ovf_data", bus.rsp_data === 32'h8000_0000);
        chk("ovf_flags", {bus.rsp_ovf, bus.rsp_zero} === 2'b10);
        cyc();

        // Backpressure: r0 response held, r1 waits, non-owner rsp_ready ignored.
        bus.r0_rsp_ready = 1'b0;
        drive(1'b0, 4'h0, 32'd10, 32'd20, 1'b0, 1'b0);
        wait_ready(1'b0);
        cyc();
        bus.r0_valid = 1'b0;
        drive(1'b1, 4'h4, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1'b0);
        wait_rsp(1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_r1_ready", bus.r1_ready === 1'b0);
            chk("bp_rsp_data", bus.rsp_data === 32'd30);
            chk("bp_rsp_valid", bus.r0_rsp_valid === 1'b1);
            cyc();
        end
        bus.r0_rsp_ready = 1'b1;
        cyc();
        chk("bp_r1_ready_after", bus.r1_ready === 1'b1);
        cyc();
        bus.r1_valid = 1'b0;
        chk("bp_r1_alu_a", alu_a === 32'h0000_00FF);
        chk("bp_r1_alu_sel", alu_sel === 4'd4);
        wait_rsp(1'b1);
        cyc();

        // Reset during a multiply: no response, then normal service.
        drive(1'b0, 4'h2, 32'd9, 32'd9, 1'b0, 1'b0);
        wait_ready(1'b0);
        cyc();
        bus.r0_valid = 1'b0;
        cyc();
        chk("midrst_busy", busy === 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_rsp", {bus.r0_rsp_valid, bus.r1_rsp_valid} === 2'b00);
            cyc();
        end
        drive(1'b0, 4'h0, 32'd1, 32'd2, 1'b0, 1'b0);
        wait_ready(1'b0);
        cyc();
        bus.r0_valid = 1'b0;
        wait_rsp(1'b0);
        chk("post_rst_data", bus.rsp_data === 32'd3);
        cyc();

        chk("sb_drained", sb_q.size() == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
